// File: rtl/pipeline_collector.sv
// pipeline_collector: follows each `en` through the upstream pipeline latency,
// captures the matching `y` word into a small FIFO, and presents the FIFO head on
// a valid/ready stream. `stall` warns the upstream driver before the FIFO fills.
module pipeline_collector #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en_in,
    input  logic [WIDTH-1:0]           y_in,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stall,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [LATENCY-1:0] sr;
    logic [IW-1:0]      inflight;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               push;
    logic               pop;
    logic               full;
    logic [SW-1:0]      occupancy;

    assign push      = sr[LATENCY-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == CW'(DEPTH));
    assign out_data  = mem[rd_ptr];

    // Occupancy counts queued words plus words still travelling through the pipeline.
    always_comb begin
        occupancy = SW'(count) + SW'(inflight);
        stall     = (occupancy >= SW'(DEPTH));
    end

    // Delay line marking which pipeline output slots carry a real word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr[0] <= en_in;
            for (int i = 1; i < LATENCY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Number of enables issued whose words have not yet reached the capture point.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else if (en_in && !push) begin
            inflight <= inflight + IW'(1);
        end else if (!en_in && push) begin
            inflight <= inflight - IW'(1);
        end
    end

    // FIFO storage and write pointer; a full FIFO only accepts when the head leaves.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && (pop || !full)) begin
            mem[wr_ptr] <= y_in;
            wr_ptr      <= wr_ptr + PW'(1);
        end
    end

    // Read pointer advances on every accepted output word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Word count kept apart from the pointers so full and empty never alias.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !pop && !full) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    // Sticky flag for a captured word lost to a full FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && !pop && full) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_collector.sv
// Bench for pipeline_collector: models the upstream pipeline as a two-stage data
// delay line and scoreboards the words that should leave the output stream.
module tb_pipeline_collector;

    logic       clock;
    logic       reset;
    logic       en_in;
    logic [7:0] y_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       stall;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] dline0;
    logic [7:0] dline1;

    pipeline_collector #(.WIDTH(8), .LATENCY(2), .DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .en_in(en_in),
        .y_in(y_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .stall(stall),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle: drive inputs, feed the pipeline model, log accepted output words.
    task automatic cycle(input logic en, input logic [7:0] d, input logic rdy);
        en_in     = en;
        out_ready = rdy;
        y_in      = dline1;
        dline1    = dline0;
        dline0    = d;
        if (reset && out_valid && out_ready) got_q.push_back(out_data);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        en_in     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        @(posedge clock);
        #1;
        reset  = 1'b1;
        dline0 = 8'hEE;
        dline1 = 8'hEE;
        exp_q.delete();
        got_q.delete();
    endtask

    // Accept output words until the FIFO is empty, within a cycle budget.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (count != 0 && n < 20) begin
            cycle(1'b0, 8'hEE, 1'b1);
            n++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'hEE, 1'b1);
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL %s drain_timeout count=%0d required=0", name, count);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset     = 1'b0;
        out_ready = 1'b0;
        dline0    = 8'h09;
        dline1    = 8'h09;
        #2;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'h09, 1'b0);
            checks++;
            if ({out_valid, count, stall, overflow} !== 6'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold cyc=%0d valid=%b count=%0d stall=%b ovf=%b required all 0",
                         i, out_valid, count, stall, overflow);
            end
        end
        en_in = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h09, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("[TB] FAIL reset_release cyc=%0d valid=%b count=%0d required 0/0", i, out_valid, count);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] e;
        $display("[TB] test_single");
        do_reset();
        cycle(1'b1, 8'h09, 1'b0);
        exp_q.push_back(8'h09);
        cycle(1'b0, 8'hEE, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_early valid=%b required=0", out_valid);
        end
        cycle(1'b0, 8'hEE, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h09 || count !== 3'd1) begin
            failures++;
            $display("[TB] FAIL single_capture valid=%b data=%h count=%0d required 1/09/1", out_valid, out_data, count);
        end
        cycle(1'b0, 8'hEE, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL single_pop valid=%b count=%0d required 0/0", out_valid, count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL single_word missing required=%h", e);
            end else if (got_q[0] !== e) begin
                failures++;
                $display("[TB] FAIL single_word got=%h required=%h", got_q.pop_front(), e);
            end else void'(got_q.pop_front());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        $display("[TB] test_overflow");
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (i <= 4) exp_q.push_back(8'(i));
            if (i == 3) begin
                checks++;
                if (stall !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_early stall=%b required=0", stall);
                end
            end
            if (i == 4) begin
                checks++;
                if (stall !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL stall_assert stall=%b required=1", stall);
                end
            end
        end
        cycle(1'b0, 8'hEE, 1'b0);
        cycle(1'b0, 8'hEE, 1'b0);
        checks++;
        if (count !== 3'd4 || overflow !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_state count=%0d ovf=%b stall=%b required 4/1/1", count, overflow, stall);
        end
        drain("overflow");
        checks++;
        if (overflow !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_sticky ovf=%b stall=%b required 1/0", overflow, stall);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL overflow_word missing required=%h", e);
            end else if (got_q[0] !== e) begin
                failures++;
                $display("[TB] FAIL overflow_word got=%h required=%h", got_q.pop_front(), e);
            end else void'(got_q.pop_front());
        end
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL overflow_extra words=%0d required=0", got_q.size());
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] e;
        $display("[TB] test_full_push_pop");
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'h11 + i), 1'b0);
            exp_q.push_back(8'(8'h11 + i));
        end
        cycle(1'b0, 8'hEE, 1'b0);
        cycle(1'b0, 8'hEE, 1'b0);
        cycle(1'b1, 8'h15, 1'b0);
        exp_q.push_back(8'h15);
        cycle(1'b0, 8'hEE, 1'b0);
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL full_before count=%0d required=4", count);
        end
        cycle(1'b0, 8'hEE, 1'b1);
        checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || out_data !== 8'h12) begin
            failures++;
            $display("[TB] FAIL full_push_pop count=%0d ovf=%b head=%h required 4/0/12", count, overflow, out_data);
        end
        drain("full");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL full_word missing required=%h", e);
            end else if (got_q[0] !== e) begin
                failures++;
                $display("[TB] FAIL full_word got=%h required=%h", got_q.pop_front(), e);
            end else void'(got_q.pop_front());
        end
    endtask

    task automatic test_gap_pattern();
        logic [7:0] e;
        $display("[TB] test_gap_pattern");
        do_reset();
        cycle(1'b1, 8'hA0, 1'b0);
        exp_q.push_back(8'hA0);
        cycle(1'b0, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        exp_q.push_back(8'hA2);
        cycle(1'b0, 8'hEE, 1'b0);
        cycle(1'b0, 8'hEE, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("[TB] FAIL gap_count count=%0d required=2", count);
        end
        drain("gap");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL gap_word missing required=%h", e);
            end else if (got_q[0] !== e) begin
                failures++;
                $display("[TB] FAIL gap_word got=%h required=%h", got_q.pop_front(), e);
            end else void'(got_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_burst();
        $display("[TB] test_reset_mid_burst");
        do_reset();
        cycle(1'b1, 8'h21, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h23, 1'b0);
        cycle(1'b0, 8'hEE, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("[TB] FAIL burst_count count=%0d required=2", count);
        end
        en_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, count, stall, overflow} !== 6'b0 || out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL async_clear valid=%b count=%0d stall=%b ovf=%b data=%h required all 0",
                     out_valid, count, stall, overflow, out_data);
        end
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'hEE, 1'b1);
            checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("[TB] FAIL post_reset_capture cyc=%0d valid=%b count=%0d required 0/0", i, out_valid, count);
            end
        end
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL post_reset_words words=%0d required=0", got_q.size());
        end
    endtask

    initial begin
        reset     = 1'b0;
        en_in     = 1'b0;
        out_ready = 1'b0;
        y_in      = 8'h00;
        dline0    = 8'hEE;
        dline1    = 8'hEE;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_gap_pattern();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
